// File: rtl/dcache_data_port_ctrl.sv
// Arbitrates the single D-cache data-array port between line refills, byte-masked
// stores (sequenced as a read-modify-write) and all-way load lookups.
module dcache_data_port_ctrl #(
   parameter int NUM_WAYS            = 4,
   parameter int NUM_BANKS           = 4,
   parameter int SETS_PER_BANK_WIDTH = 8,
   parameter int BLOCK_WIDTH         = 512,
   parameter int STARVE_CYCLES       = 4,
   localparam int BANK_W = $clog2(NUM_BANKS),
   localparam int IDX_W  = SETS_PER_BANK_WIDTH + BANK_W,
   localparam int WAY_W  = $clog2(NUM_WAYS),
   localparam int BE_W   = BLOCK_WIDTH / 8,
   localparam int CNT_W  = $clog2(STARVE_CYCLES + 1)
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            refill_valid_i,
   output logic                            refill_ready_o,
   input  logic [IDX_W-1:0]                refill_index_i,
   input  logic [WAY_W-1:0]                refill_way_i,
   input  logic [BLOCK_WIDTH-1:0]          refill_data_i,
   input  logic                            st_valid_i,
   output logic                            st_ready_o,
   input  logic [IDX_W-1:0]                st_index_i,
   input  logic [WAY_W-1:0]                st_way_i,
   input  logic [BLOCK_WIDTH-1:0]          st_wdata_i,
   input  logic [BE_W-1:0]                 st_be_i,
   input  logic                            ld_valid_i,
   output logic                            ld_ready_o,
   input  logic [IDX_W-1:0]                ld_index_i,
   output logic                            ld_rvalid_o,
   output logic [NUM_WAYS*BLOCK_WIDTH-1:0] ld_rdata_o,
   output logic [SETS_PER_BANK_WIDTH-1:0]  arr_bank_addr_o,
   output logic [BANK_W-1:0]               arr_bank_sel_o,
   output logic [NUM_WAYS-1:0]             arr_we_way_mask_o,
   output logic [BLOCK_WIDTH-1:0]          arr_wdata_o,
   input  logic [NUM_WAYS*BLOCK_WIDTH-1:0] arr_rdata_i
);

   typedef enum logic {IDLE, ST_WR} state_t;

   state_t               r_state;
   state_t               w_nextState;
   logic [CNT_W-1:0]     r_starveCnt;
   logic                 r_ldRvalid;
   logic [IDX_W-1:0]     r_stIndex;
   logic [WAY_W-1:0]     r_stWay;
   logic [BLOCK_WIDTH-1:0] r_stWdata;
   logic [BE_W-1:0]      r_stBe;

   logic                 w_starving;
   logic                 w_refillGrant;
   logic                 w_stGrant;
   logic                 w_ldGrant;
   logic [IDX_W-1:0]     w_arrIndex;
   logic [BLOCK_WIDTH-1:0] w_oldLine;
   logic [BLOCK_WIDTH-1:0] w_merged;

   assign w_starving = (r_starveCnt == CNT_W'(STARVE_CYCLES));

   // Reset suppresses every grant, so a reset landing on ST_WR drops the write.
   always_comb begin
      refill_ready_o = 1'b0;
      st_ready_o     = 1'b0;
      ld_ready_o     = 1'b0;
      if (!rst_i && r_state == IDLE) begin
         if (w_starving) begin
            ld_ready_o = 1'b1;
         end else begin
            refill_ready_o = 1'b1;
            st_ready_o     = !refill_valid_i;
            ld_ready_o     = !refill_valid_i && !st_valid_i;
         end
      end
   end

   assign w_refillGrant = refill_valid_i && refill_ready_o;
   assign w_stGrant     = st_valid_i && st_ready_o;
   assign w_ldGrant     = ld_valid_i && ld_ready_o;

   always_comb begin
      w_merged  = '0;
      w_oldLine = arr_rdata_i[int'(r_stWay)*BLOCK_WIDTH +: BLOCK_WIDTH];
      for (int k = 0; k < BE_W; k++) begin
         w_merged[k*8 +: 8] = r_stBe[k] ? r_stWdata[k*8 +: 8] : w_oldLine[k*8 +: 8];
      end
   end

   always_comb begin
      w_nextState       = r_state;
      w_arrIndex        = '0;
      arr_we_way_mask_o = '0;
      arr_wdata_o       = '0;
      if (!rst_i) begin
         case (r_state)
            IDLE: begin
               if (w_refillGrant) begin
                  w_arrIndex        = refill_index_i;
                  arr_we_way_mask_o = NUM_WAYS'(1) << refill_way_i;
                  arr_wdata_o       = refill_data_i;
               end else if (w_stGrant) begin
                  w_arrIndex  = st_index_i;
                  w_nextState = ST_WR;
               end else if (w_ldGrant) begin
                  w_arrIndex = ld_index_i;
               end
            end
            ST_WR: begin
               w_arrIndex        = r_stIndex;
               arr_we_way_mask_o = NUM_WAYS'(1) << r_stWay;
               arr_wdata_o       = w_merged;
               w_nextState       = IDLE;
            end
            default: w_nextState = IDLE;
         endcase
      end
   end

   assign arr_bank_addr_o = w_arrIndex[IDX_W-1:BANK_W];
   assign arr_bank_sel_o  = w_arrIndex[BANK_W-1:0];
   assign ld_rdata_o      = arr_rdata_i;
   assign ld_rvalid_o     = r_ldRvalid;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= IDLE;
         r_starveCnt <= '0;
         r_ldRvalid  <= 1'b0;
      end else begin
         r_state    <= w_nextState;
         r_ldRvalid <= w_ldGrant;
         if (!ld_valid_i || ld_ready_o) begin
            r_starveCnt <= '0;
         end else if (!w_starving) begin
            r_starveCnt <= r_starveCnt + CNT_W'(1);
         end
      end
   end

   // Store payload is only guaranteed stable in its accept cycle.
   always_ff @(posedge clk_i) begin
      if (w_stGrant) begin
         r_stIndex <= st_index_i;
         r_stWay   <= st_way_i;
         r_stWdata <= st_wdata_i;
         r_stBe    <= st_be_i;
      end
   end

endmodule

// File: tb/tb_dcache_data_port_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic, all checked
// against a transaction-level model of the array contents and grant rules.
module tb_dcache_data_port_ctrl;

   localparam int NUM_WAYS = 4;
   localparam int BW       = 512;
   localparam int STARVE   = 4;
   localparam int IDX_W    = 10;
   localparam int WAY_W    = 2;
   localparam int BE_W     = BW / 8;
   localparam int DEPTH    = 1 << IDX_W;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   logic refill_valid_i, refill_ready_o;
   logic [IDX_W-1:0] refill_index_i;
   logic [WAY_W-1:0] refill_way_i;
   logic [BW-1:0] refill_data_i;
   logic st_valid_i, st_ready_o;
   logic [IDX_W-1:0] st_index_i;
   logic [WAY_W-1:0] st_way_i;
   logic [BW-1:0] st_wdata_i;
   logic [BE_W-1:0] st_be_i;
   logic ld_valid_i, ld_ready_o, ld_rvalid_o;
   logic [IDX_W-1:0] ld_index_i;
   logic [NUM_WAYS*BW-1:0] ld_rdata_o;
   logic [7:0] arr_bank_addr_o;
   logic [1:0] arr_bank_sel_o;
   logic [NUM_WAYS-1:0] arr_we_way_mask_o;
   logic [BW-1:0] arr_wdata_o;
   logic [NUM_WAYS*BW-1:0] arr_rdata_i = '0;

   int testCount = 0;
   int failCount = 0;

   always #5 clk_i = ~clk_i;

   dcache_data_port_ctrl dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .refill_valid_i(refill_valid_i), .refill_ready_o(refill_ready_o),
      .refill_index_i(refill_index_i), .refill_way_i(refill_way_i),
      .refill_data_i(refill_data_i),
      .st_valid_i(st_valid_i), .st_ready_o(st_ready_o),
      .st_index_i(st_index_i), .st_way_i(st_way_i),
      .st_wdata_i(st_wdata_i), .st_be_i(st_be_i),
      .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o),
      .ld_index_i(ld_index_i), .ld_rvalid_o(ld_rvalid_o), .ld_rdata_o(ld_rdata_o),
      .arr_bank_addr_o(arr_bank_addr_o), .arr_bank_sel_o(arr_bank_sel_o),
      .arr_we_way_mask_o(arr_we_way_mask_o), .arr_wdata_o(arr_wdata_o),
      .arr_rdata_i(arr_rdata_i)
   );

   // Data array: registered read of all ways, whole-block write per masked way.
   logic [BW-1:0] mem [NUM_WAYS][DEPTH];
   logic [IDX_W-1:0] arrAddr;
   always @(posedge clk_i) begin
      arrAddr = {arr_bank_addr_o, arr_bank_sel_o};
      for (int w = 0; w < NUM_WAYS; w++) begin
         arr_rdata_i[w*BW +: BW] <= mem[w][arrAddr];
         if (arr_we_way_mask_o[w]) mem[w][arrAddr] <= arr_wdata_o;
      end
   end

   task automatic checkOutput(input string tag, input logic [BW-1:0] observed,
                              input logic [BW-1:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   function automatic logic [BW-1:0] randLine();
      logic [BW-1:0] v;
      for (int i = 0; i < BW/32; i++) v[i*32 +: 32] = $urandom();
      return v;
   endfunction

   function automatic logic [BE_W-1:0] randBe();
      logic [BE_W-1:0] v;
      for (int i = 0; i < BE_W/32; i++) v[i*32 +: 32] = $urandom();
      return v;
   endfunction

   // Reference model: expected line contents plus outstanding store/load bookkeeping.
   logic [BW-1:0] shadow [NUM_WAYS][DEPTH];
   logic enMon = 1'b0;
   logic mBusy = 1'b0, mRvalid = 1'b0;
   int   mStarve = 0;
   logic [WAY_W-1:0] mWay;
   logic [IDX_W-1:0] mIdx;
   logic [BW-1:0] mMerged;
   logic [BW-1:0] mLdExp [NUM_WAYS];
   logic eRef, eSt, eLd, accR, accS, accL;
   logic [NUM_WAYS-1:0] eMask;
   logic [IDX_W-1:0] eIdx;
   logic [BW-1:0] eWdata, oldLine;

   always @(negedge clk_i) begin
      if (enMon) begin
         eRef = 0; eSt = 0; eLd = 0; eMask = '0; eIdx = '0; eWdata = '0;
         if (!rst_i && !mBusy) begin
            if (mStarve >= STARVE) eLd = 1'b1;
            else begin
               eRef = 1'b1;
               eSt  = !refill_valid_i;
               eLd  = !refill_valid_i && !st_valid_i;
            end
         end
         accR = refill_valid_i && eRef;
         accS = st_valid_i && eSt;
         accL = ld_valid_i && eLd;
         if (!rst_i) begin
            if (mBusy) begin
               eMask = 4'(1) << mWay; eIdx = mIdx; eWdata = mMerged;
            end else if (accR) begin
               eMask = 4'(1) << refill_way_i; eIdx = refill_index_i; eWdata = refill_data_i;
            end else if (accS) eIdx = st_index_i;
            else if (accL) eIdx = ld_index_i;
         end
         checkOutput("refill_ready", BW'(refill_ready_o), BW'(eRef));
         checkOutput("st_ready", BW'(st_ready_o), BW'(eSt));
         checkOutput("ld_ready", BW'(ld_ready_o), BW'(eLd));
         checkOutput("we_mask", BW'(arr_we_way_mask_o), BW'(eMask));
         checkOutput("bank_addr", BW'(arr_bank_addr_o), BW'(eIdx[IDX_W-1:2]));
         checkOutput("bank_sel", BW'(arr_bank_sel_o), BW'(eIdx[1:0]));
         if (eMask != '0) checkOutput("wdata", arr_wdata_o, eWdata);
         checkOutput("ld_rvalid", BW'(ld_rvalid_o), BW'(mRvalid));
         if (mRvalid && ld_rvalid_o) begin
            for (int w = 0; w < NUM_WAYS; w++)
               checkOutput($sformatf("ld_rdata_w%0d", w), ld_rdata_o[w*BW +: BW], mLdExp[w]);
         end
         if (rst_i) begin
            mBusy = 0; mRvalid = 0; mStarve = 0;
         end else begin
            if (mBusy) shadow[mWay][mIdx] = mMerged;
            if (accR) shadow[refill_way_i][refill_index_i] = refill_data_i;
            mRvalid = accL;
            if (accL) for (int w = 0; w < NUM_WAYS; w++) mLdExp[w] = shadow[w][ld_index_i];
            mBusy = accS;
            if (accS) begin
               mWay = st_way_i; mIdx = st_index_i;
               oldLine = shadow[st_way_i][st_index_i];
               for (int k = 0; k < BE_W; k++)
                  mMerged[k*8 +: 8] = st_be_i[k] ? st_wdata_i[k*8 +: 8] : oldLine[k*8 +: 8];
            end
            if (!ld_valid_i || accL) mStarve = 0;
            else if (mStarve < STARVE) mStarve++;
         end
      end
   end

   task automatic applyStimulus(input logic rv, input logic [IDX_W-1:0] ri,
                                input logic [WAY_W-1:0] rw, input logic [BW-1:0] rd,
                                input logic sv, input logic [IDX_W-1:0] si,
                                input logic [WAY_W-1:0] sw, input logic [BW-1:0] sd,
                                input logic [BE_W-1:0] sbe,
                                input logic lv, input logic [IDX_W-1:0] li);
      refill_valid_i = rv; refill_index_i = ri; refill_way_i = rw; refill_data_i = rd;
      st_valid_i = sv; st_index_i = si; st_way_i = sw; st_wdata_i = sd; st_be_i = sbe;
      ld_valid_i = lv; ld_index_i = li;
   endtask

   task automatic idleInputs();
      applyStimulus(0, '0, '0, randLine(), 0, '0, '0, randLine(), randBe(), 0, '0);
   endtask

   task automatic nextCycle();
      @(posedge clk_i);
      #1;
   endtask

   logic [BW-1:0] lineA, lineB, expLine;
   logic [BE_W-1:0] be;

   initial begin
      for (int w = 0; w < NUM_WAYS; w++)
         for (int i = 0; i < DEPTH; i++) begin
            mem[w][i] = '0; shadow[w][i] = '0;
         end
      idleInputs();
      rst_i = 1'b1;
      nextCycle();
      enMon = 1'b1;
      nextCycle();
      @(negedge clk_i);
      checkOutput("reset_rvalid", BW'(ld_rvalid_o), '0);
      checkOutput("reset_mask", BW'(arr_we_way_mask_o), '0);
      nextCycle();
      rst_i = 1'b0;
      @(negedge clk_i);
      checkOutput("idle_refill_ready", BW'(refill_ready_o), BW'(1));
      checkOutput("idle_ld_ready", BW'(ld_ready_o), BW'(1));
      checkOutput("idle_addr", BW'(arr_bank_addr_o), '0);

      // Refill line A into index 0x2C5 way 2, then load it back.
      lineA = randLine();
      nextCycle();
      applyStimulus(1, 10'h2C5, 2'd2, lineA, 0, '0, '0, '0, '0, 0, '0);
      @(negedge clk_i);
      checkOutput("refill_mask", BW'(arr_we_way_mask_o), BW'(4'b0100));
      checkOutput("refill_sel", BW'(arr_bank_sel_o), BW'(1));
      checkOutput("refill_addr", BW'(arr_bank_addr_o), BW'(8'hB1));
      nextCycle();
      applyStimulus(0, '0, '0, '0, 0, '0, '0, '0, '0, 1, 10'h2C5);
      nextCycle();
      idleInputs();
      @(negedge clk_i);
      checkOutput("reload_rvalid", BW'(ld_rvalid_o), BW'(1));
      checkOutput("reload_way2", ld_rdata_o[2*BW +: BW], lineA);

      // Byte-0 store of 0xEE into the same line.
      lineB = randLine();
      lineB[7:0] = 8'hEE;
      be = '0; be[0] = 1'b1;
      expLine = lineA; expLine[7:0] = 8'hEE;
      nextCycle();
      applyStimulus(0, '0, '0, '0, 1, 10'h2C5, 2'd2, lineB, be, 0, '0);
      @(negedge clk_i);
      checkOutput("store_c1_mask", BW'(arr_we_way_mask_o), '0);
      nextCycle();
      idleInputs();
      @(negedge clk_i);
      checkOutput("store_c2_mask", BW'(arr_we_way_mask_o), BW'(4'b0100));
      checkOutput("store_c2_ready", BW'(st_ready_o), '0);
      checkOutput("store_c2_wdata", arr_wdata_o, expLine);
      nextCycle();
      applyStimulus(0, '0, '0, '0, 0, '0, '0, '0, '0, 1, 10'h2C5);
      nextCycle();
      idleInputs();
      @(negedge clk_i);
      checkOutput("store_reload", ld_rdata_o[2*BW +: BW], expLine);

      // Refill, store and load all requesting at once.
      nextCycle();
      applyStimulus(1, 10'd5, 2'd1, randLine(), 1, 10'd9, 2'd0, randLine(), randBe(), 1, 10'd5);
      @(negedge clk_i);
      checkOutput("tri_c0_refill", BW'(refill_ready_o), BW'(1));
      checkOutput("tri_c0_st", BW'(st_ready_o), '0);
      checkOutput("tri_c0_ld", BW'(ld_ready_o), '0);
      nextCycle();
      refill_valid_i = 1'b0;
      @(negedge clk_i);
      checkOutput("tri_c1_st", BW'(st_ready_o), BW'(1));
      checkOutput("tri_c1_ld", BW'(ld_ready_o), '0);
      nextCycle();
      st_valid_i = 1'b0;
      @(negedge clk_i);
      checkOutput("tri_c2_ld", BW'(ld_ready_o), '0);
      nextCycle();
      @(negedge clk_i);
      checkOutput("tri_c3_ld", BW'(ld_ready_o), BW'(1));
      nextCycle();
      idleInputs();
      @(negedge clk_i);
      checkOutput("tri_rvalid", BW'(ld_rvalid_o), BW'(1));

      // Continuous refill traffic starving a pending load.
      for (int c = 0; c < 6; c++) begin
         nextCycle();
         applyStimulus(1, 4'($urandom()), 2'($urandom()), randLine(), 0, '0, '0, '0, '0,
                       1, 10'h2C5);
         @(negedge clk_i);
         checkOutput($sformatf("starve_c%0d_ld", c), BW'(ld_ready_o), BW'(c == 4));
         checkOutput($sformatf("starve_c%0d_refill", c), BW'(refill_ready_o), BW'(c != 4));
      end

      // Three back-to-back loads.
      for (int c = 0; c < 5; c++) begin
         nextCycle();
         if (c < 3) applyStimulus(0, '0, '0, '0, 0, '0, '0, '0, '0, 1, IDX_W'(c + 1));
         else idleInputs();
         @(negedge clk_i);
         checkOutput($sformatf("burst_c%0d_rvalid", c), BW'(ld_rvalid_o), BW'(c >= 1 && c <= 3));
      end

      // Reset landing on the write cycle of a store.
      nextCycle();
      applyStimulus(0, '0, '0, '0, 1, 10'h2C5, 2'd2, randLine(), '1, 0, '0);
      nextCycle();
      idleInputs();
      rst_i = 1'b1;
      @(negedge clk_i);
      checkOutput("rst_stwr_mask", BW'(arr_we_way_mask_o), '0);
      nextCycle();
      rst_i = 1'b0;
      @(negedge clk_i);
      checkOutput("rst_rvalid", BW'(ld_rvalid_o), '0);
      nextCycle();
      applyStimulus(0, '0, '0, '0, 0, '0, '0, '0, '0, 1, 10'h2C5);
      nextCycle();
      idleInputs();
      @(negedge clk_i);
      checkOutput("rst_line_kept", ld_rdata_o[2*BW +: BW], expLine);

      // Randomized traffic over a small set of lines.
      for (int c = 0; c < 2000; c++) begin
         nextCycle();
         applyStimulus(($urandom_range(99) < 40), 4'($urandom()), 2'($urandom()), randLine(),
                       ($urandom_range(99) < 30), 4'($urandom()), 2'($urandom()), randLine(),
                       randBe(), ($urandom_range(99) < 70), 4'($urandom()));
         rst_i = ($urandom_range(299) == 0);
      end
      nextCycle();
      idleInputs();
      rst_i = 1'b0;
      repeat (3) nextCycle();
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/dcache_data_port_ctrl.md
# dcache_data_port_ctrl

Controller that shares the single address port of the D-cache data array between three requesters: line refill, byte-masked store, and load lookup. Stores are sequenced as a two-cycle read-modify-write, because the array writes whole blocks only. Load read data for all ways is returned one cycle after acceptance for tag-side way selection. Sits between the D-cache pipeline/refill unit and the data array.

## Interface
- NUM_WAYS, 4, ways in the array
- NUM_BANKS, 4, banks; index low bits select the bank
- SETS_PER_BANK_WIDTH, 8, log2 sets per bank; index high bits
- BLOCK_WIDTH, 512, line width in bits; must be a multiple of 8
- STARVE_CYCLES, 4, consecutive stalled cycles after which a load gets priority
- Derived: IDX_W = SETS_PER_BANK_WIDTH + $clog2(NUM_BANKS); WAY_W = $clog2(NUM_WAYS)

Ports:
- clk_i  in  1  clock; single clock domain
- rst_i  in  1  synchronous, active-high reset
- refill_valid_i / refill_ready_o  in/out  1  refill handshake
- refill_index_i  in  IDX_W  set index
- refill_way_i  in  WAY_W  target way
- refill_data_i  in  BLOCK_WIDTH  full line
- st_valid_i / st_ready_o  in/out  1  store handshake
- st_index_i  in  IDX_W;  st_way_i  in  WAY_W (hit way)
- st_wdata_i  in  BLOCK_WIDTH;  st_be_i  in  BLOCK_WIDTH/8  byte enables
- ld_valid_i / ld_ready_o  in/out  1  load handshake
- ld_index_i  in  IDX_W
- ld_rvalid_o  out  1  read data valid, one-cycle pulse
- ld_rdata_o  out  NUM_WAYS x BLOCK_WIDTH  all-way read data
- arr_bank_addr_o  out  SETS_PER_BANK_WIDTH  index[IDX_W-1:$clog2(NUM_BANKS)]
- arr_bank_sel_o  out  $clog2(NUM_BANKS)  index low bits
- arr_we_way_mask_o  out  NUM_WAYS  one-hot write mask, 0 for reads
- arr_wdata_o  out  BLOCK_WIDTH
- arr_rdata_i  in  NUM_WAYS x BLOCK_WIDTH  data for the address presented in the previous cycle

## Operation
- States: IDLE, ST_WR. Array port carries at most one operation per cycle.
- IDLE grant order: starving load > refill > store > load. A handshake completes in the cycle valid&&ready.
- Refill grant: drive the index, arr_we_way_mask_o = onehot(refill_way_i), arr_wdata_o = refill_data_i. Single cycle; state stays IDLE.
- Store grant: drive st_index_i as a read (mask 0). Capture index, way, wdata and be. Go to ST_WR.
- ST_WR: drive the captured index, mask = onehot(way), wdata = per-byte merge (be[k] ? wdata byte k : arr_rdata_i[way] byte k). All readies 0. Return to IDLE.
- Load grant: drive ld_index_i as a read with mask 0. Set ld_rvalid_o for the next cycle. Loads pipeline one per cycle.
- ld_rdata_o = arr_rdata_i, combinational passthrough; meaningful only while ld_rvalid_o = 1.
- Starve counter: increments (saturating at STARVE_CYCLES) each cycle ld_valid_i && !ld_ready_o. It clears on load accept or when ld_valid_i = 0. When counter == STARVE_CYCLES in IDLE, ld_ready_o = 1 and refill_ready_o = st_ready_o = 0.
- No address-hazard checking. Upstream orders same-line refill/store/load.
- Refill/store payload need only be stable in the accept cycle.

## Timing
- Reset values: state IDLE, starve counter 0, ld_rvalid_o 0, arr_we_way_mask_o 0.
- With no grant: arr_bank_addr_o/arr_bank_sel_o = 0, arr_wdata_o = 0.
- Ready outputs are combinational from state, counter and the valids. In IDLE with no starvation:
  - refill_ready_o = 1
  - st_ready_o = !refill_valid_i
  - ld_ready_o = !refill_valid_i && !st_valid_i
- Latencies:
  - Refill write lands at the clock edge ending its accept cycle.
  - Store occupies 2 cycles; the merged write lands at the end of cycle 2.
  - Load data is valid in cycle accept+1.
- Back-to-back: store then anything has a 1-cycle gap (ST_WR). Refill and load can each be accepted every cycle.
- Reset asserted mid-operation: from the next cycle, state is IDLE, the pending ST_WR write is dropped, and ld_rvalid_o = 0. Reset has priority over all grants.

## Test plan
- Refill, index 0x2C5 (bank 1, addr 0xB1), way 2, data pattern A -> mask 4'b0100, sel 1, addr 0xB1 in the accept cycle. A later load of 0x2C5 returns A on way 2 with ld_rvalid_o one cycle after accept.
- Store to line A, way 2, be = only byte 0 set, wdata byte0 = 0xEE -> cycle 1 mask 0, cycle 2 mask 4'b0100. A reload shows A with byte 0 = 0xEE; ready is 0 in cycle 2.
- Refill, store and load all valid in the same cycle -> refill accepted. The store is accepted next cycle, then ST_WR. The load is accepted after that, with no drops.
- Refill held valid every cycle with a load pending -> the load is stalled 4 cycles, then accepted in cycle 5 with refill_ready_o = 0 that cycle. The counter returns to 0.
- Loads to indices 1, 2, 3 on consecutive cycles -> ld_rvalid_o high for 3 consecutive cycles, with data in order.
- rst_i asserted during ST_WR -> no write occurs (mask stays 0). The line is unchanged on reload and ld_rvalid_o = 0.
